// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the RV32I instruction-fetch stage:
//   default reset PC, bubble instruction and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction-memory request/response bundle.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_rdata : instruction word, valid with imem_ready (memory -> fetch)
//   imem_ready : response strobe, any number of cycles after the request (memory -> fetch)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register. Priority: flush > hold > load; otherwise retains.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     load_i/flush_i/hold_i : control
//     inst_i/pc_i/pc4_i     : fetched instruction, its PC and PC+4
//     inst_o/pc_o/pc4_o     : registered values
//     valid_o               : registered entry is a real instruction
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, pc_q, pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      // Reset and flush both leave a bubble with zeroed PC fields.
      inst_q  <= NOP_INST;
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      inst_q  <= inst_q;
      pc_q    <= pc_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   RV32I instruction-fetch stage: PC register, instruction-memory handshake
//   and IF/ID register. Handles memory wait states, stalls and redirects that
//   arrive while a fetch is outstanding (the in-flight response is dropped).
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     pc_sel      : 0 = redirect to br_target, 1 = sequential
//     br_target   : redirect target (low two bits ignored)
//     stall       : hold PC and IF/ID
//     imem        : instruction-memory request/response bundle
//     if_id_inst/if_id_pc/if_id_pc4/if_id_valid : IF/ID register outputs
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_sel,
  input  logic [31:0]   br_target,
  input  logic          stall,
  fetch_stage_if.master imem,
  output logic [31:0]   if_id_inst,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_pc4,
  output logic          if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  saved_q, saved_d;
  logic         load, flush, hold;
  logic [31:0]  target_aligned;

  assign target_aligned = br_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      saved_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    load    = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (!pc_sel) begin
          // Redirect wins over stall: flush and either jump now or wait
          // for the outstanding response to drain in S_KILL.
          flush = 1'b1;
          if (imem.imem_ready) begin
            pc_d = target_aligned;
          end else begin
            saved_d = target_aligned;
            state_d = S_KILL;
          end
        end else if (stall) begin
          hold = 1'b1;
        end else if (imem.imem_ready) begin
          load = 1'b1;
          pc_d = pc_plus4(pc_q);
        end
      end
      S_KILL: begin
        // IF/ID already holds the bubble; nothing loads here.
        if (!pc_sel) saved_d = target_aligned;
        if (imem.imem_ready) begin
          pc_d    = pc_sel ? saved_q : target_aligned;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_KILL);
  assign imem.imem_addr = pc_q;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .hold_i  (hold),
    .inst_i  (imem.imem_rdata),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4(pc_q)),
    .inst_o  (if_id_inst),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. The memory returns addr ^ 32'h5A5A_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] br_target;
  logic        stall;
  logic [31:0] if_id_inst, if_id_pc, if_id_pc4;
  logic        if_id_valid;
  int          passed = 0;
  int          total  = 0;

  fetch_stage_if imem_bus ();

  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'h5A5A_0000;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .br_target   (br_target),
    .stall       (stall),
    .imem        (imem_bus),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cyc(input logic r, input logic sel, input logic [31:0] tgt,
                     input logic stl, input logic rdy);
    rst = r; pc_sel = sel; br_target = tgt; stall = stl; imem_bus.imem_ready = rdy;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b sel=%0b tgt=%h stall=%0b rdy=%0b -> req=%0b addr=%h inst=%h pc=%h pc4=%h v=%0b",
             $time, r, sel, tgt, stl, rdy, imem_bus.imem_req, imem_bus.imem_addr,
             if_id_inst, if_id_pc, if_id_pc4, if_id_valid);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic v);
    chk({tag, ".inst"},  if_id_inst, inst);
    chk({tag, ".pc"},    if_id_pc, pc);
    chk({tag, ".pc4"},   if_id_pc4, pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"},  {31'd0, imem_bus.imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem_bus.imem_addr, addr);
  endtask

  initial begin
    // Reset
    cyc(1, 1, 32'h0, 0, 0);
    cyc(1, 0, 32'h40, 1, 1);  // rst overrides other inputs
    chk_req("reset", 0, 32'h0);
    chk_ifid("reset", 32'h13, 32'h0, 32'h0, 0);

    // S_RESET -> S_FETCH, no load on that edge
    cyc(0, 1, 32'h0, 0, 1);
    chk_req("first_req", 1, 32'h0);
    chk_ifid("first_req", 32'h13, 32'h0, 32'h0, 0);

    // Back-to-back fetches
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seq0", 32'h5A5A_0000, 32'h0, 32'h4, 1);
    chk_req("seq0", 1, 32'h4);
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seq4", 32'h5A5A_0004, 32'h4, 32'h8, 1);
    chk_req("seq4", 1, 32'h8);

    // Wait states at 0x8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h0, 0, 0);
      chk_req("wait", 1, 32'h8);
      chk_ifid("wait", 32'h5A5A_0004, 32'h4, 32'h8, 1);
    end
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seq8", 32'h5A5A_0008, 32'h8, 32'hC, 1);
    chk_req("seq8", 1, 32'hC);

    // Stall with ready high
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 32'h0, 1, 1);
      chk_ifid("stall", 32'h5A5A_0008, 32'h8, 32'hC, 1);
      chk_req("stall", 1, 32'hC);
    end
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seqC", 32'h5A5A_000C, 32'hC, 32'h10, 1);
    chk_req("seqC", 1, 32'h10);

    // Redirect with ready high (stall also high: redirect still flushes)
    cyc(0, 0, 32'h100, 1, 1);
    chk_ifid("redir", 32'h13, 32'h0, 32'h0, 0);
    chk_req("redir", 1, 32'h100);
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seq100", 32'h5A5A_0100, 32'h100, 32'h104, 1);
    chk_req("seq100", 1, 32'h104);

    // Redirect while fetch at 0x104 is outstanding, then overwrite
    cyc(0, 0, 32'h200, 0, 0);
    chk_ifid("kill1", 32'h13, 32'h0, 32'h0, 0);
    chk_req("kill1", 1, 32'h104);
    cyc(0, 0, 32'h302, 0, 0);  // low bits forced to zero
    chk_ifid("kill2", 32'h13, 32'h0, 32'h0, 0);
    chk_req("kill2", 1, 32'h104);
    cyc(0, 1, 32'h0, 0, 0);
    chk_ifid("kill3", 32'h13, 32'h0, 32'h0, 0);
    chk_req("kill3", 1, 32'h104);
    cyc(0, 1, 32'h0, 0, 1);    // stale response dropped
    chk_ifid("kill_drop", 32'h13, 32'h0, 32'h0, 0);
    chk_req("kill_drop", 1, 32'h300);
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("seq300", 32'h5A5A_0300, 32'h300, 32'h304, 1);
    chk_req("seq300", 1, 32'h304);

    // PC wrap at 0xFFFF_FFFC
    cyc(0, 0, 32'hFFFF_FFFC, 0, 1);
    chk_req("wrap_redir", 1, 32'hFFFF_FFFC);
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("wrap", 32'hA5A5_FFFC, 32'hFFFF_FFFC, 32'h0, 1);
    chk_req("wrap", 1, 32'h0);
    cyc(0, 1, 32'h0, 0, 1);
    chk_ifid("wrap0", 32'h5A5A_0000, 32'h0, 32'h4, 1);
    chk_req("wrap0", 1, 32'h4);

    // Reset in the middle of a wait
    cyc(0, 1, 32'h0, 0, 0);
    chk_req("prerst", 1, 32'h4);
    cyc(1, 1, 32'h0, 0, 0);
    chk_req("midrst", 0, 32'h0);
    chk_ifid("midrst", 32'h13, 32'h0, 32'h0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    chk_req("postrst", 1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
